calc1_port_driver: RTL and testbench

- Request sequencer sitting directly upstream of one calc1 request port (req1..req4).
- Accepts a complete operation (cmd, operand1, operand2) over a valid/ready handshake.
- Serialises the operation into calc1's two-cycle command protocol, waits for the port's out_resp/out_data, and returns the result over a second valid/ready handshake.
- One instance per calc1 port; instances are fully independent.

---
 rtl/calc1_port_driver.sv | 209 ++++++++++++++++++++
 tb/tb_calc1_port_driver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// ---------------------------------------------------------------------------
// calc1_port_driver
//
// Request sequencer for one calc1 request port. An operation (cmd, operand1,
// operand2) is accepted over a valid/ready handshake. It is serialised into
// calc1's two-cycle command protocol. The driver then waits for the port's
// response and hands the result downstream over a second valid/ready
// handshake. Only one operation is in flight at a time.
//
// Optional feature macro: CALC1_DRV_TIMEOUT_EN
//    When defined, a wait counter aborts the WAIT state after TIMEOUT_CYCLES
//    cycles without a response and reports resp = 3 (timeout). When the macro
//    is undefined, no counter exists and WAIT lasts until calc1 answers.
//
// Parameters
//    TIMEOUT_CYCLES : silent WAIT cycles before timeout (1..255)
//    CNT_W          : wait counter width, must hold TIMEOUT_CYCLES
//
// Ports
//    c_clk, reset            clock, asynchronous active-high reset
//    op_valid/op_ready       upstream operation handshake
//    op_cmd, op_data1/2      operation: 1 add, 2 sub, 5 shl, 6 shr
//    req_cmd_out/data_out    command/data towards calc1 reqN inputs
//    duv_resp_in/data_in     calc1 out_respN / out_dataN
//    res_valid/res_ready     downstream result handshake
//    res_resp, res_data      1 ok, 2 overflow/invalid, 3 timeout/reject
//    busy                    high whenever the driver is not idle
// ---------------------------------------------------------------------------
module calc1_port_driver #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [0:3]  op_cmd,
   input  logic [0:31] op_data1,
   input  logic [0:31] op_data2,
   output logic [0:3]  req_cmd_out,
   output logic [0:31] req_data_out,
   input  logic [0:1]  duv_resp_in,
   input  logic [0:31] duv_data_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [0:1]  res_resp,
   output logic [0:31] res_data,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND1,
      ST_SEND2,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Catch parameter combinations the wait counter cannot represent.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
       TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : gBadParams
      $error("calc1_port_driver: TIMEOUT_CYCLES out of range for CNT_W");
   end

   state_t       state_q, state_d;
   logic         op_ready_q, op_ready_d;
   logic [0:3]   req_cmd_q, req_cmd_d;
   logic [0:31]  req_data_q, req_data_d;
   logic         res_valid_q, res_valid_d;
   logic [0:1]   res_resp_q, res_resp_d;
   logic [0:31]  res_data_q, res_data_d;
   logic         busy_q, busy_d;
   logic [0:31]  data2_q, data2_d;
`ifdef CALC1_DRV_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cntPlusOne;
`endif

   logic cmdLegal;

   // Only the four calc1 operations are forwarded; anything else is rejected
   // locally without touching the calc1 port.
   always_comb begin
      cmdLegal = (op_cmd == 4'd1) || (op_cmd == 4'd2) ||
                 (op_cmd == 4'd5) || (op_cmd == 4'd6);
   end

`ifdef CALC1_DRV_TIMEOUT_EN
   // Extra bit so the compare against TIMEOUT_CYCLES never sees a wrapped value.
   always_comb begin
      cntPlusOne = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   end
`endif

   // Next-state and next-output logic. Every output is registered, so the
   // values computed here are the ones the next state will present.
   always_comb begin
      state_d     = state_q;
      op_ready_d  = 1'b0;
      req_cmd_d   = '0;
      req_data_d  = '0;
      res_valid_d = res_valid_q;
      res_resp_d  = res_resp_q;
      res_data_d  = res_data_q;
      data2_d     = data2_q;
`ifdef CALC1_DRV_TIMEOUT_EN
      cnt_d       = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            op_ready_d = 1'b1;
            // op_ready_q keeps the first cycle after reset from accepting.
            if (op_valid && op_ready_q) begin
               op_ready_d = 1'b0;
               data2_d    = op_data2;
               if (cmdLegal) begin
                  state_d    = ST_SEND1;
                  req_cmd_d  = op_cmd;
                  req_data_d = op_data1;
               end else begin
                  state_d     = ST_RESP;
                  res_valid_d = 1'b1;
                  res_resp_d  = 2'd3;
                  res_data_d  = '0;
               end
            end
         end
         ST_SEND1: begin
            state_d    = ST_SEND2;
            req_data_d = data2_q;
         end
         ST_SEND2: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (duv_resp_in != 2'd0) begin
               state_d     = ST_RESP;
               res_valid_d = 1'b1;
               res_resp_d  = duv_resp_in;
               res_data_d  = (duv_resp_in == 2'd1) ? duv_data_in : '0;
            end
`ifdef CALC1_DRV_TIMEOUT_EN
            else begin
               cnt_d = (&cnt_q) ? cnt_q : cntPlusOne[CNT_W-1:0];
               if (cntPlusOne >= (CNT_W+1)'(TIMEOUT_CYCLES)) begin
                  state_d     = ST_RESP;
                  res_valid_d = 1'b1;
                  res_resp_d  = 2'd3;
                  res_data_d  = '0;
               end
            end
`endif
         end
         ST_RESP: begin
            if (res_ready) begin
               state_d     = ST_IDLE;
               op_ready_d  = 1'b1;
               res_valid_d = 1'b0;
               res_resp_d  = '0;
               res_data_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any operation silently.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_ready_q  <= 1'b0;
         req_cmd_q   <= '0;
         req_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_resp_q  <= '0;
         res_data_q  <= '0;
         busy_q      <= 1'b0;
         data2_q     <= '0;
`ifdef CALC1_DRV_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_ready_q  <= op_ready_d;
         req_cmd_q   <= req_cmd_d;
         req_data_q  <= req_data_d;
         res_valid_q <= res_valid_d;
         res_resp_q  <= res_resp_d;
         res_data_q  <= res_data_d;
         busy_q      <= busy_d;
         data2_q     <= data2_d;
`ifdef CALC1_DRV_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign op_ready     = op_ready_q;
   assign req_cmd_out  = req_cmd_q;
   assign req_data_out = req_data_q;
   assign res_valid    = res_valid_q;
   assign res_resp     = res_resp_q;
   assign res_data     = res_data_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// ---------------------------------------------------------------------------
// tb_calc1_port_driver
//
// Self-checking bench for calc1_port_driver. A small calc1 stand-in answers
// the commands the driver emits. A timestamp-based model predicts every
// registered output cycle by cycle, and directed operations carry
// hand-computed result values.
// ---------------------------------------------------------------------------
module tb_calc1_port_driver;

   localparam int TIMEOUT = 16;

   logic        c_clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [0:3]  op_cmd = '0;
   logic [0:31] op_data1 = '0;
   logic [0:31] op_data2 = '0;
   logic [0:3]  req_cmd_out;
   logic [0:31] req_data_out;
   logic [0:1]  duv_resp_in = '0;
   logic [0:31] duv_data_in = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [0:1]  res_resp;
   logic [0:31] res_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   calc1_port_driver #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
      .c_clk(c_clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2),
      .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
      .duv_resp_in(duv_resp_in), .duv_data_in(duv_data_in),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_resp(res_resp), .res_data(res_data), .busy(busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 c_clk = ~c_clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timestamp model: remembers when the operation was accepted and when its
   // response arrived, and derives the expected outputs of each cycle from those.
   bit          modelArmed = 0;
   bit          haveOp = 0, gotResp = 0, legal = 0;
   int          cyc = 0, tAcc = 0, accCnt = 0;
   logic [3:0]  mCmd = '0;
   logic [31:0] mA = '0, mB = '0, rData = '0;
   logic [1:0]  rResp = '0;
   logic        expReady = 0, expBusy = 0, expValid = 0;
   logic [1:0]  expResp = '0;
   logic [31:0] expData = '0, expReqData = '0;
   logic [3:0]  expReqCmd = '0;

   always @(posedge c_clk or posedge reset) begin
      if (reset) begin
         modelArmed = 1;
         haveOp = 0; gotResp = 0;
         expReady = 0; expBusy = 0; expValid = 0; expResp = '0;
         expData = '0; expReqCmd = '0; expReqData = '0;
      end else begin
         cyc++;
         if (haveOp && expValid && res_ready) begin
            haveOp = 0;
         end else if (!haveOp && expReady && op_valid) begin
            haveOp = 1; tAcc = cyc; accCnt++;
            mCmd = op_cmd; mA = op_data1; mB = op_data2;
            legal = (mCmd == 1) || (mCmd == 2) || (mCmd == 5) || (mCmd == 6);
            gotResp = !legal; rResp = legal ? 2'd0 : 2'd3; rData = '0;
         end else if (haveOp && legal && !gotResp && (cyc - 1 >= tAcc + 2)) begin
            if (duv_resp_in != 0) begin
               gotResp = 1; rResp = duv_resp_in;
               rData = (duv_resp_in == 2'd1) ? duv_data_in : 32'd0;
            end
`ifdef CALC1_DRV_TIMEOUT_EN
            else if (cyc - tAcc - 2 >= TIMEOUT) begin
               gotResp = 1; rResp = 2'd3; rData = '0;
            end
`endif
         end
         expReady   = !haveOp;
         expBusy    = haveOp;
         expValid   = haveOp && gotResp;
         expResp    = expValid ? rResp : 2'd0;
         expData    = expValid ? rData : 32'd0;
         expReqCmd  = (haveOp && legal && cyc == tAcc) ? mCmd : 4'd0;
         expReqData = (haveOp && legal && cyc == tAcc)     ? mA :
                      (haveOp && legal && cyc == tAcc + 1) ? mB : 32'd0;
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge c_clk) begin
      if (modelArmed && !reset) begin
         checkOutput("op_ready", op_ready, expReady);
         checkOutput("busy", busy, expBusy);
         checkOutput("req_cmd_out", req_cmd_out, expReqCmd);
         checkOutput("req_data_out", req_data_out, expReqData);
         checkOutput("res_valid", res_valid, expValid);
         checkOutput("res_resp", res_resp, expResp);
         checkOutput("res_data", res_data, expData);
      end
   end

   // calc1 stand-in: picks up the two-cycle command, waits stubDelay cycles
   // and answers for one cycle. Muted, it never answers.
   int          stubPhase = 0, stubCount = 0, stubDelay = 0, stubSeen = 0;
   int          injReq = 0, injDone = 0;
   bit          stubMute = 0;
   logic [3:0]  sCmd = '0;
   logic [31:0] sA = '0, sB = '0;
   logic [32:0] sum;

   always @(negedge c_clk or posedge reset) begin
      if (reset) begin
         stubPhase = 0; duv_resp_in = '0; duv_data_in = '0; injDone = injReq;
      end else begin
         case (stubPhase)
            0: begin
               if (req_cmd_out != 0) begin
                  sCmd = req_cmd_out; sA = req_data_out; stubSeen++; stubPhase = 1;
               end else if (injDone != injReq) begin
                  injDone = injReq; duv_resp_in = 2'd1; duv_data_in = 32'h1234_5678;
                  stubPhase = 3;
               end
            end
            1: begin
               sB = req_data_out; stubCount = stubDelay; stubPhase = 2;
            end
            2: begin
               if (stubMute) begin
                  stubPhase = 0;
               end else if (stubCount == 0) begin
                  case (sCmd)
                     4'd1: begin
                        sum = {1'b0, sA} + {1'b0, sB};
                        duv_resp_in = sum[32] ? 2'd2 : 2'd1;
                        duv_data_in = sum[32] ? 32'hDEAD_BEEF : sum[31:0];
                     end
                     4'd2: begin
                        duv_resp_in = (sA < sB) ? 2'd2 : 2'd1;
                        duv_data_in = (sA < sB) ? 32'hDEAD_BEEF : sA - sB;
                     end
                     4'd5: begin duv_resp_in = 2'd1; duv_data_in = sA << sB[4:0]; end
                     4'd6: begin duv_resp_in = 2'd1; duv_data_in = sA >> sB[4:0]; end
                     default: begin duv_resp_in = 2'd2; duv_data_in = '0; end
                  endcase
                  stubPhase = 3;
               end else begin
                  stubCount--;
               end
            end
            default: begin
               duv_resp_in = '0; duv_data_in = '0; stubPhase = 0;
            end
         endcase
      end
   end

   int          validWait = 0;
   logic [1:0]  lastResp;
   logic [31:0] lastData;

   // Submits one operation from a falling edge, optionally stalls the result
   // for hold cycles (while offering a competing op), and checks the result.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] a,
                                input logic [31:0] b, input int hold,
                                input logic [1:0] er, input logic [31:0] ed,
                                input string name);
      int startAcc;
      int n;
      startAcc = accCnt;
      op_cmd = cmd; op_data1 = a; op_data2 = b; op_valid = 1'b1;
      res_ready = (hold == 0);
      n = 0;
      while (accCnt == startAcc && n < 20) begin @(negedge c_clk); n++; end
      op_valid = 1'b0;
      if (accCnt == startAcc) begin
         checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
         return;
      end
      n = 0;
      while (!res_valid && n < 200) begin @(negedge c_clk); n++; end
      validWait = n;
      if (!res_valid) begin
         checkOutput({name, " result timeout"}, 32'd0, 32'd1);
         res_ready = 1'b1;
         return;
      end
      if (hold > 0) begin
         op_cmd = 4'd1; op_data1 = 32'h55; op_data2 = 32'h66; op_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            checkOutput({name, " hold valid"}, res_valid, 1);
            checkOutput({name, " hold resp"}, res_resp, er);
            checkOutput({name, " hold data"}, res_data, ed);
            checkOutput({name, " hold op_ready"}, op_ready, 0);
            @(negedge c_clk);
         end
         op_valid = 1'b0;
         checkOutput({name, " no second accept"}, accCnt, startAcc + 1);
         res_ready = 1'b1;
      end
      lastResp = res_resp; lastData = res_data;
      @(negedge c_clk);
      checkOutput({name, " resp"}, lastResp, er);
      checkOutput({name, " data"}, lastData, ed);
      checkOutput({name, " ready after"}, op_ready, 1);
   endtask

   initial begin
      int seenBefore;
      #1 reset = 1'b1;
      #1;
      checkOutput("rst op_ready", op_ready, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst res_valid", res_valid, 0);
      checkOutput("rst req_cmd", req_cmd_out, 0);
      checkOutput("rst res_data", res_data, 0);
      repeat (2) @(negedge c_clk);
      #2 reset = 1'b0;
      @(negedge c_clk);
      checkOutput("ready after reset", op_ready, 1);

      // Add 1 + 1FF_FFFF, immediate response.
      stubDelay = 0;
      applyStimulus(4'd1, 32'h1, 32'h01FF_FFFF, 0, 2'd1, 32'h0200_0000, "add");
      checkOutput("add latency", validWait, 3);
      checkOutput("add stub cmd", sCmd, 1);
      checkOutput("add stub data1", sA, 32'h1);
      checkOutput("add stub data2", sB, 32'h01FF_FFFF);

      // Overflowing add: data forced to zero.
      applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h1, 0, 2'd2, 32'd0, "add ovf");

      // Sub and shr with a slower calc1.
      stubDelay = 3;
      applyStimulus(4'd2, 32'd10, 32'd3, 0, 2'd1, 32'd7, "sub");
      applyStimulus(4'd6, 32'h8000_0000, 32'd4, 0, 2'd1, 32'h0800_0000, "shr");
      stubDelay = 0;

      // Local rejects never reach calc1.
      seenBefore = stubSeen;
      applyStimulus(4'd3, 32'h11, 32'h22, 0, 2'd3, 32'd0, "reject3");
      checkOutput("reject3 latency", validWait, 0);
      applyStimulus(4'd0, 32'h33, 32'h44, 0, 2'd3, 32'd0, "reject0");
      checkOutput("reject no calc1 cmd", stubSeen, seenBefore);

      // Shl with the result stalled for 5 cycles.
      applyStimulus(4'd5, 32'h1, 32'h1, 5, 2'd1, 32'h2, "shl stall");

`ifdef CALC1_DRV_TIMEOUT_EN
      stubMute = 1;
      applyStimulus(4'd1, 32'd5, 32'd6, 0, 2'd3, 32'd0, "timeout");
      checkOutput("timeout latency", validWait, TIMEOUT + 2);
      stubMute = 0;
`else
      stubMute = 1;
      op_cmd = 4'd1; op_data1 = 32'd5; op_data2 = 32'd6; op_valid = 1'b1;
      @(negedge c_clk);
      op_valid = 1'b0;
      repeat (110) @(negedge c_clk);
      checkOutput("no timeout valid", res_valid, 0);
      checkOutput("no timeout busy", busy, 1);
      #2 reset = 1'b1;
      @(negedge c_clk);
      #2 reset = 1'b0;
      @(negedge c_clk);
      stubMute = 0;
`endif

      // Reset pulse while waiting for calc1.
      stubDelay = 10;
      op_cmd = 4'd1; op_data1 = 32'd3; op_data2 = 32'd4; op_valid = 1'b1;
      @(negedge c_clk);
      op_valid = 1'b0;
      repeat (4) @(negedge c_clk);
      checkOutput("wait busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async busy", busy, 0);
      checkOutput("async op_ready", op_ready, 0);
      checkOutput("async res_valid", res_valid, 0);
      checkOutput("async req_cmd", req_cmd_out, 0);
      checkOutput("async req_data", req_data_out, 0);
      checkOutput("async res_resp", res_resp, 0);
      @(negedge c_clk);
      #2 reset = 1'b0;
      @(negedge c_clk);
      injReq++;
      repeat (4) begin
         @(negedge c_clk);
         checkOutput("stray resp ignored", res_valid, 0);
      end
      stubDelay = 0;
      applyStimulus(4'd1, 32'd3, 32'd4, 0, 2'd1, 32'd7, "post reset add");

      repeat (2) @(negedge c_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
